sgd_hbm_rd_sched: RTL
=====================

Name: sgd_hbm_rd_sched

Overview:
Read-request scheduler for one SGD engine's HBM AXI read port. On start it latches the job parameters and walks epochs × mini-batches, issuing AR bursts: the label (B) line(s) first, then the feature (A) lines for each batch. It enforces an outstanding-beat credit limit, counts returned R beats, and raises done after the last beat of the last epoch. It sits between the user-module parameter block and the engine's axi_mm read channel.

Parameters:
MAX_BURST 16 — max beats per AR burst (arlen ≤ MAX_BURST-1)
MAX_OUTSTANDING 64 — max AR beats issued but not yet returned on R
ID_A 0 — arid for A bursts
ID_B 1 — arid for B bursts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; job begins on first cycle high while IDLE
addr_a  in  64  A base byte address, 64B aligned
addr_b  in  64  B base byte address, 64B aligned
mini_batch_size  in  32  samples per batch, nonzero multiple of 16
number_of_epochs  in  32  epochs, ≥1
dimension  in  32  features per sample, nonzero multiple of 16
number_of_samples  in  32  total samples, ≥1
number_of_bits  in  32  bit planes per feature, 1..32
araddr  out  64  AR byte address
arlen  out  8  AR burst length minus 1
arid  out  8  ID_A or ID_B
arvalid  out  1  AR valid
arready  in  1  AR ready
rvalid  in  1  R valid
rlast  in  1  R last (informational; not used for counting)
rready  out  1  R ready, held 1 when not in reset
busy  out  1  job active
done  out  1  one-cycle pulse on completion
epoch_cnt  out  32  current epoch index
batch_cnt  out  32  current batch index within epoch

Behaviour:
- Reset (async): state IDLE; arvalid=0, araddr=0, arlen=0, arid=0, rready=0, busy=0, done=0, epoch_cnt=0, batch_cnt=0, outstanding=0. rready=1 from first clock after reset release.
- Parameters latched on the IDLE→CALC transition; input changes during a job ignored. start while busy ignored.
- L = (dimension>>4)*number_of_bits (A lines per sample), computed in CALC (one cycle).
- Batch k: s0 = k*mini_batch_size; n = min(mini_batch_size, number_of_samples-s0); batches per epoch = ceil(number_of_samples/mini_batch_size).
- B region: ceil(n/16) lines starting at addr_b + (s0>>4)*64. A region: n*L lines starting at addr_a + s0*L*64.
- Each region split into bursts of min(MAX_BURST, remaining lines); araddr advances by (arlen+1)*64 per burst.
- States: IDLE → CALC (start) → ISSUE_B → ISSUE_A → NEXT → (ISSUE_B next batch | DONE_WAIT).
- ISSUE_B/ISSUE_A: arvalid asserted only when outstanding + (arlen+1) ≤ MAX_OUTSTANDING; araddr/arlen/arid stable while arvalid && !arready; arvalid never drops without handshake. Moves on when region's last burst handshakes.
- NEXT (one cycle): batch_cnt++; at last batch, batch_cnt←0, epoch_cnt++; after last epoch → DONE_WAIT.
- DONE_WAIT: wait outstanding==0, then done=1 for one cycle, busy=0, → IDLE. epoch_cnt holds number_of_epochs until next start.
- outstanding: +(arlen+1) on AR handshake, −1 per rvalid&&rready beat, both in same cycle net-applied; never negative (beats with outstanding==0 ignored, saturate at 0).
- busy=1 from CALC through DONE_WAIT inclusive.
- No drain between batches or epochs; AR issue is back-to-back when credit allows (one burst per cycle max).

Test Plan:
- dimension=256, bits=8, MB=16, samples=32, epochs=1, arready=1, R returns 1 beat/cycle after 4-cycle latency → per batch 1 B burst (arlen=0, arid=1) then 128 A bursts arlen=15; batch 1 B araddr=addr_b+64, A araddr starts addr_a+16*128*64; done once after 2+256 bursts, all 4098 beats returned.
- samples=7288, MB=16, dimension=16, bits=1, epochs=3 → 456 batches/epoch; last batch n=8: B 1 line, A 8 lines (arlen=7); done after epoch_cnt reaches 3.
- R held invalid, arready=1 → exactly 4 A bursts of 16 accepted, arvalid stays high, no 5th handshake until a beat returns; one beat back still blocks (need 16 credits), 16 beats unblocks.
- arready low 10 cycles during ISSUE_A → araddr/arlen/arid stable, arvalid continuously high.
- AR handshake and R beat same cycle with outstanding=48, arlen=15 → outstanding becomes 63.
- rst_n low mid-ISSUE_A → all outputs immediately to reset values; later stray rvalid beats leave outstanding at 0; new start runs cleanly from batch 0.

Source files
------------

// File: rtl/sgd_hbm_rd_sched.sv
// sgd_hbm_rd_sched: AXI read-request scheduler feeding one SGD engine from HBM.
// Walks epochs x mini-batches, issuing label (B) bursts then feature (A) bursts
// per batch under an outstanding-beat credit limit, and pulses done when the
// last beat of the last epoch has returned.
module sgd_hbm_rd_sched #(
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned ID_A            = 0,
  parameter int unsigned ID_B            = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] addr_a,
  input  logic [63:0] addr_b,
  input  logic [31:0] mini_batch_size,
  input  logic [31:0] number_of_epochs,
  input  logic [31:0] dimension,
  input  logic [31:0] number_of_samples,
  input  logic [31:0] number_of_bits,
  output logic [63:0] araddr,
  output logic [7:0]  arlen,
  output logic [7:0]  arid,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic        busy,
  output logic        done,
  output logic [31:0] epoch_cnt,
  output logic [31:0] batch_cnt
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + MAX_BURST + 1);
  localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE_B,
    S_ISSUE_A,
    S_NEXT,
    S_DONE_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched job parameters
  logic [63:0] r_addr_a;
  logic [63:0] r_addr_b;
  logic [31:0] r_mb;
  logic [31:0] r_ne;
  logic [31:0] r_dim;
  logic [31:0] r_ns;
  logic [31:0] r_bits;
  logic [63:0] r_l;

  // Walk state
  logic [31:0]      r_s0;
  logic [63:0]      r_ptr;
  logic [63:0]      r_rem;
  logic [OUT_W-1:0] r_out;

  // Registered outputs
  logic [63:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [7:0]  r_arid;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_epoch;
  logic [31:0] r_batch;

  logic             w_hs;
  logic             w_dec;
  logic [OUT_W-1:0] w_add;
  logic [OUT_W-1:0] w_out_next;
  logic             w_last_batch;
  logic             w_last_epoch;
  logic [31:0]      w_s0_sel;
  logic [31:0]      w_rem_samp;
  logic [31:0]      w_n;
  logic [63:0]      w_b_lines;
  logic [63:0]      w_b_base;
  logic [63:0]      w_a_lines;
  logic [63:0]      w_a_base;
  logic             w_issuing;
  logic             w_slot_free;
  logic [LEN_W-1:0] w_burst;
  logic             w_credit_ok;
  logic             w_region_end;
  logic             w_load;
  logic             w_unused;

  assign araddr    = r_araddr;
  assign arlen     = r_arlen;
  assign arid      = r_arid;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign epoch_cnt = r_epoch;
  assign batch_cnt = r_batch;

  // rlast is informational only; beats are counted from rvalid && rready.
  assign w_unused = rlast;

  // Credit accounting: handshake adds a burst, each accepted beat retires one (never below 0)
  assign w_hs       = r_arvalid & arready;
  assign w_dec      = rvalid & r_rready & (r_out != '0);
  assign w_add      = w_hs ? (OUT_W'(r_arlen) + OUT_W'(1)) : '0;
  assign w_out_next = r_out + w_add - OUT_W'(w_dec);

  // Batch geometry; in NEXT it looks ahead to the batch about to start
  assign w_last_batch = (r_ns - r_s0) <= r_mb;
  assign w_last_epoch = (r_epoch + 32'd1) >= r_ne;
  assign w_s0_sel     = (r_state == S_NEXT) ? (w_last_batch ? 32'd0 : r_s0 + r_mb) : r_s0;
  assign w_rem_samp   = r_ns - w_s0_sel;
  assign w_n          = (w_rem_samp < r_mb) ? w_rem_samp : r_mb;
  assign w_b_lines    = 64'((33'(w_n) + 33'd15) >> 4);
  assign w_b_base     = r_addr_b + 64'({w_s0_sel[31:4], 6'b0});
  assign w_a_lines    = 64'(w_n) * r_l;
  assign w_a_base     = r_addr_a + ((64'(r_s0) * r_l) << 6);

  // Burst issue: load a new burst when the AR slot is free and credit covers it
  assign w_issuing    = (r_state == S_ISSUE_B) || (r_state == S_ISSUE_A);
  assign w_slot_free  = !r_arvalid || w_hs;
  assign w_burst      = (r_rem >= 64'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(r_rem);
  assign w_credit_ok  = (32'(w_out_next) + 32'(w_burst)) <= 32'(MAX_OUTSTANDING);
  assign w_region_end = w_issuing && w_slot_free && (r_rem == '0);
  assign w_load       = w_issuing && w_slot_free && (r_rem != '0) && w_credit_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_CALC;
      S_CALC:      w_state_nxt = S_ISSUE_B;
      S_ISSUE_B:   if (w_region_end) w_state_nxt = S_ISSUE_A;
      S_ISSUE_A:   if (w_region_end) w_state_nxt = S_NEXT;
      S_NEXT:      w_state_nxt = (w_last_batch && w_last_epoch) ? S_DONE_WAIT : S_ISSUE_B;
      S_DONE_WAIT: if (r_out == '0) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: parameter latch, region pointers, AR channel, counters, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_mb      <= '0;
      r_ne      <= '0;
      r_dim     <= '0;
      r_ns      <= '0;
      r_bits    <= '0;
      r_l       <= '0;
      r_s0      <= '0;
      r_ptr     <= '0;
      r_rem     <= '0;
      r_out     <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arid    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_epoch   <= '0;
      r_batch   <= '0;
    end else begin
      r_rready <= 1'b1;
      r_done   <= 1'b0;
      r_out    <= w_out_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr_a <= addr_a;
            r_addr_b <= addr_b;
            r_mb     <= mini_batch_size;
            r_ne     <= number_of_epochs;
            r_dim    <= dimension;
            r_ns     <= number_of_samples;
            r_bits   <= number_of_bits;
            r_s0     <= '0;
            r_epoch  <= '0;
            r_batch  <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          r_l   <= 64'(r_dim >> 4) * 64'(r_bits);
          r_ptr <= w_b_base;
          r_rem <= w_b_lines;
        end
        S_ISSUE_B, S_ISSUE_A: begin
          if (w_load) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_ptr;
            r_arlen   <= 8'(w_burst - LEN_W'(1));
            r_arid    <= (r_state == S_ISSUE_B) ? 8'(ID_B) : 8'(ID_A);
            r_ptr     <= r_ptr + (64'(w_burst) << 6);
            r_rem     <= r_rem - 64'(w_burst);
          end else if (w_hs) begin
            r_arvalid <= 1'b0;
          end
          if (w_region_end && (r_state == S_ISSUE_B)) begin
            r_ptr <= w_a_base;
            r_rem <= w_a_lines;
          end
        end
        S_NEXT: begin
          r_s0  <= w_s0_sel;
          r_ptr <= w_b_base;
          r_rem <= w_b_lines;
          if (w_last_batch) begin
            r_batch <= '0;
            r_epoch <= r_epoch + 32'd1;
          end else begin
            r_batch <= r_batch + 32'd1;
          end
        end
        S_DONE_WAIT: begin
          if (r_out == '0) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
